// File: rtl/softmax_exp_stream_if.sv
// Score input stream and exp/sum output stream of the softmax exponent stage.
interface softmax_exp_stream_if #(
   parameter int INT_W   = 5,
   parameter int FRAC_W  = 12,
   parameter int VEC_LEN = 8
) ();
   localparam int X_W   = INT_W + FRAC_W;
   localparam int OUT_W = 16;
   localparam int SUM_W = OUT_W + $clog2(VEC_LEN);

   logic             in_valid;
   logic             in_ready;
   logic [X_W-1:0]   in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_exp;
   logic             out_last;
   logic [SUM_W-1:0] out_sum;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_exp, out_last, out_sum
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_exp, out_last, out_sum
   );
endinterface

// File: rtl/softmax_exp_stream.sv
// Buffers one score vector, tracks its maximum, then streams exp(x - max) through a
// 4-stage LUT + Taylor pipeline with the running sum presented on the last beat.
module softmax_exp_stream #(
   parameter int INT_W   = 5,
   parameter int FRAC_W  = 12,
   parameter int VEC_LEN = 8
) (
   input logic clk,
   input logic rst,
   softmax_exp_stream_if.slave io_bus
);
   localparam int X_W   = INT_W + FRAC_W;
   localparam int D_W   = X_W + 1;
   localparam int N_W   = INT_W + 1;
   localparam int R_W   = FRAC_W - 4;
   localparam int OUT_W = 16;
   localparam int SUM_W = OUT_W + $clog2(VEC_LEN);
   localparam int IDX_W = $clog2(VEC_LEN);
   // T is built on a 2^16 scale; the residual r has FRAC_W fractional bits (needs 8 <= FRAC_W <= 16)
   localparam int SH_R  = 16 - FRAC_W;
   localparam int SH_SQ = 2 * FRAC_W - 15;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

   function automatic logic [15:0] lut_int(input int unsigned k);
      case (k)
         0:       lut_int = 16'd65535;
         1:       lut_int = 16'd24109;
         2:       lut_int = 16'd8869;
         3:       lut_int = 16'd3263;
         4:       lut_int = 16'd1200;
         5:       lut_int = 16'd442;
         6:       lut_int = 16'd162;
         7:       lut_int = 16'd60;
         8:       lut_int = 16'd22;
         9:       lut_int = 16'd8;
         10:      lut_int = 16'd3;
         11:      lut_int = 16'd1;
         default: lut_int = 16'd0;
      endcase
   endfunction

   function automatic logic [15:0] lut_hi(input logic [3:0] j);
      case (j)
         4'd0:  lut_hi = 16'd65535;
         4'd1:  lut_hi = 16'd61565;
         4'd2:  lut_hi = 16'd57835;
         4'd3:  lut_hi = 16'd54331;
         4'd4:  lut_hi = 16'd51039;
         4'd5:  lut_hi = 16'd47947;
         4'd6:  lut_hi = 16'd45042;
         4'd7:  lut_hi = 16'd42313;
         4'd8:  lut_hi = 16'd39750;
         4'd9:  lut_hi = 16'd37341;
         4'd10: lut_hi = 16'd35079;
         4'd11: lut_hi = 16'd32954;
         4'd12: lut_hi = 16'd30957;
         4'd13: lut_hi = 16'd29081;
         4'd14: lut_hi = 16'd27319;
         4'd15: lut_hi = 16'd25664;
      endcase
   endfunction

   typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

   state_t             r_state, w_state_next;
   logic [IDX_W-1:0]   r_wr_idx, r_rd_idx;
   logic [X_W-1:0]     r_max;
   logic [SUM_W-1:0]   r_acc;
   logic [X_W-1:0]     r_buf [VEC_LEN];
   logic [X_W-1:0]     r_s1_x;
   logic               r_s1_v, r_s1_last;
   logic               r_s2_v, r_s2_last, r_s2_one;
   logic [15:0]        r_s2_lint, r_s2_lhi;
   logic [R_W-1:0]     r_s2_r;
   logic [2*R_W-1:0]   r_s2_rsq;
   logic               r_s3_v, r_s3_last, r_s3_one;
   logic [15:0]        r_s3_p1, r_s3_t;
   logic               r_out_valid, r_out_last;
   logic [15:0]        r_out_exp;

   logic               w_in_ready, w_wr_en, w_issue, w_adv, w_out_hs;
   logic [D_W-1:0]     w_d, w_m;
   logic [N_W-1:0]     w_n;
   logic [FRAC_W-1:0]  w_f;
   logic [R_W-1:0]     w_r;
   logic [31:0]        w_t;
   logic [15:0]        w_p1, w_exp;

   // A held output beat freezes every stage and the issue counter together
   assign w_adv    = !r_out_valid || io_bus.out_ready;
   assign w_out_hs = r_out_valid && io_bus.out_ready;
   assign w_wr_en  = io_bus.in_valid && w_in_ready;

   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_issue      = 1'b0;
      case (r_state)
         LOAD: begin
            w_in_ready = !rst;
            if (io_bus.in_valid && w_in_ready && r_wr_idx == LAST_IDX)
               w_state_next = COMPUTE;
         end
         COMPUTE: begin
            w_issue = w_adv;
            if (w_adv && r_rd_idx == LAST_IDX)
               w_state_next = DRAIN;
         end
         DRAIN: begin
            if (w_out_hs && r_out_last)
               w_state_next = LOAD;
         end
         default: w_state_next = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= LOAD;
         r_wr_idx <= '0;
         r_rd_idx <= '0;
         r_max    <= '0;
         r_acc    <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_wr_en) begin
            r_wr_idx <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + IDX_W'(1);
            if (r_wr_idx == '0 || $signed(io_bus.in_data) > $signed(r_max))
               r_max <= io_bus.in_data;
         end
         if (w_issue)
            r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + IDX_W'(1);
         if (w_out_hs)
            r_acc <= r_out_last ? '0 : r_acc + SUM_W'(r_out_exp);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_buf[r_wr_idx] <= io_bus.in_data;
      if (w_adv)
         r_s1_x <= r_buf[r_rd_idx];
   end

   assign w_d   = {r_s1_x[X_W-1], r_s1_x} - {r_max[X_W-1], r_max};
   assign w_m   = -w_d;
   assign w_n   = w_m[D_W-1:FRAC_W];
   assign w_f   = w_m[FRAC_W-1:0];
   assign w_r   = w_f[R_W-1:0];
   assign w_t   = 32'd65536 - (32'(r_s2_r) << SH_R) + (32'(r_s2_rsq) >> SH_SQ);
   assign w_p1  = 16'((32'(r_s2_lint) * 32'(r_s2_lhi)) >> 16);
   assign w_exp = 16'((32'(r_s3_p1) * 32'(r_s3_t)) >> 16);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_v      <= 1'b0;
         r_s1_last   <= 1'b0;
         r_s2_v      <= 1'b0;
         r_s2_last   <= 1'b0;
         r_s2_one    <= 1'b0;
         r_s2_lint   <= '0;
         r_s2_lhi    <= '0;
         r_s2_r      <= '0;
         r_s2_rsq    <= '0;
         r_s3_v      <= 1'b0;
         r_s3_last   <= 1'b0;
         r_s3_one    <= 1'b0;
         r_s3_p1     <= '0;
         r_s3_t      <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_exp   <= '0;
      end else if (w_adv) begin
         r_s1_v      <= w_issue;
         r_s1_last   <= w_issue && (r_rd_idx == LAST_IDX);
         r_s2_v      <= r_s1_v;
         r_s2_last   <= r_s1_last;
         // The vector maximum itself maps exactly to full scale instead of the LUT product
         r_s2_one    <= (w_m == '0);
         r_s2_lint   <= lut_int(32'(w_n));
         r_s2_lhi    <= lut_hi(w_f[FRAC_W-1:FRAC_W-4]);
         r_s2_r      <= w_r;
         r_s2_rsq    <= (2*R_W)'(w_r) * (2*R_W)'(w_r);
         r_s3_v      <= r_s2_v;
         r_s3_last   <= r_s2_last;
         r_s3_one    <= r_s2_one;
         r_s3_p1     <= w_p1;
         r_s3_t      <= (w_t > 32'd65535) ? 16'hFFFF : w_t[15:0];
         r_out_valid <= r_s3_v;
         r_out_last  <= r_s3_v && r_s3_last;
         r_out_exp   <= !r_s3_v ? '0 : (r_s3_one ? 16'hFFFF : w_exp);
      end
   end

   assign io_bus.in_ready  = w_in_ready;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.out_exp   = r_out_exp;
   assign io_bus.out_last  = r_out_last;
   assign io_bus.out_sum   = r_out_last ? r_acc + SUM_W'(r_out_exp) : '0;
endmodule
